// File: rtl/csa_resolve_pipe.sv
// csa_resolve_pipe: pipelined carry-propagate adder that resolves a
// redundant {sum, carry} pair into SUM = (S + C) mod 2^SIZE.
// Ports: clk, reset (async, active-high), in_valid/in_ready/in_s/in_c
// (input side), out_valid/out_ready/out_sum (output side),
// out_cout (only when CSA_RESOLVE_COUT_EN is defined).
// Parameters: SIZE (width), STAGES (pipeline stages = carry chunks).
module csa_resolve_pipe #(
  parameter int SIZE   = 34,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_s,
  input  logic [SIZE-1:0] in_c,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_sum
`ifdef CSA_RESOLVE_COUT_EN
  ,
  output logic            out_cout
`endif
);

  localparam int CHUNK = (SIZE + STAGES - 1) / STAGES;

  // Per-stage state: a holds resolved low chunks plus unresolved high
  // bits of S, b holds the unresolved high bits of C (resolved chunks
  // are zeroed), cy is the carry into the next chunk.
  logic            v_q  [STAGES];
  logic [SIZE-1:0] a_q  [STAGES];
  logic [SIZE-1:0] b_q  [STAGES];
  logic            cy_q [STAGES];

  logic            v_in  [STAGES];
  logic [SIZE-1:0] a_in  [STAGES];
  logic [SIZE-1:0] b_in  [STAGES];
  logic            cy_in [STAGES];

  logic stall;

  assign stall    = v_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;
    localparam int HI = (k == STAGES - 1) ? SIZE - 1
                                          : LO + CHUNK - 1;
    localparam int W  = HI - LO + 1;

    if (k == 0) begin : g_first
      assign v_in[k]  = in_valid;
      assign a_in[k]  = in_s;
      assign b_in[k]  = in_c;
      assign cy_in[k] = 1'b0;
    end else begin : g_next
      assign v_in[k]  = v_q[k-1];
      assign a_in[k]  = a_q[k-1];
      assign b_in[k]  = b_q[k-1];
      assign cy_in[k] = cy_q[k-1];
    end

    logic [W:0]      add;
    logic [SIZE-1:0] a_d;
    logic [SIZE-1:0] b_d;

    always_comb begin
      add = {1'b0, a_in[k][HI:LO]}
          + {1'b0, b_in[k][HI:LO]}
          + {{W{1'b0}}, cy_in[k]};
      a_d = a_in[k];
      a_d[HI:LO] = add[W-1:0];
      b_d = b_in[k];
      b_d[HI:LO] = '0;
    end

    // Data only loads with a valid item so X on idle inputs never
    // enters the pipe; bubbles keep the previous contents.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        cy_q[k] <= 1'b0;
      end else if (!stall) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          a_q[k]  <= a_d;
          b_q[k]  <= b_d;
          cy_q[k] <= add[W];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_sum   = a_q[STAGES-1];

  // The final stage's b is all-zero by construction; it and (without
  // carry-out) the top carry are intentionally left unconsumed.
  logic unused_top;
`ifdef CSA_RESOLVE_COUT_EN
  assign out_cout   = cy_q[STAGES-1];
  assign unused_top = ^b_q[STAGES-1];
`else
  assign unused_top = ^{b_q[STAGES-1], cy_q[STAGES-1]};
`endif

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// tb_csa_resolve_pipe: random and directed stimulus for csa_resolve_pipe
// at STAGES=4, 1 and SIZE, checked against a plain-arithmetic model.
module tb_csa_resolve_pipe;

  localparam int SIZE = 34;
  localparam int NI   = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            out_ready;
  logic [SIZE-1:0] in_s;
  logic [SIZE-1:0] in_c;

  logic            rdy_w [NI];
  logic            vld_w [NI];
  logic [SIZE-1:0] sum_w [NI];
`ifdef CSA_RESOLVE_COUT_EN
  logic            cout_w [NI];
`endif

  logic [63:0] q [NI][$];
  logic [63:0] mon_e;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit trk = 1'b0;
  int t_cnt, t_first, t_last;
  logic [SIZE-1:0] held;

  always #5 clk = ~clk;

  csa_resolve_pipe #(.SIZE(SIZE), .STAGES(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(rdy_w[0]),
    .in_s(in_s), .in_c(in_c),
    .out_valid(vld_w[0]), .out_ready(out_ready),
    .out_sum(sum_w[0])
`ifdef CSA_RESOLVE_COUT_EN
    , .out_cout(cout_w[0])
`endif
  );

  csa_resolve_pipe #(.SIZE(SIZE), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(rdy_w[1]),
    .in_s(in_s), .in_c(in_c),
    .out_valid(vld_w[1]), .out_ready(out_ready),
    .out_sum(sum_w[1])
`ifdef CSA_RESOLVE_COUT_EN
    , .out_cout(cout_w[1])
`endif
  );

  csa_resolve_pipe #(.SIZE(SIZE), .STAGES(SIZE)) u_sn (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(rdy_w[2]),
    .in_s(in_s), .in_c(in_c),
    .out_valid(vld_w[2]), .out_ready(out_ready),
    .out_sum(sum_w[2])
`ifdef CSA_RESOLVE_COUT_EN
    , .out_cout(cout_w[2])
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [SIZE-1:0] s,
                                        input logic [SIZE-1:0] c);
    return {30'b0, s} + {30'b0, c};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : SIZE;
  endfunction

  function automatic logic [SIZE-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) r = '1;
    return r[SIZE-1:0];
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (in_valid && rdy_w[i])
          q[i].push_back(model(in_s, in_c));
        if (vld_w[i] && out_ready) begin
          if (q[i].size() == 0) begin
            chk($sformatf("spurious%0d", i), 64'(vld_w[i]), 64'd0);
          end else begin
            mon_e = q[i].pop_front();
            chk($sformatf("sum%0d", i), 64'(sum_w[i]),
                64'(mon_e[SIZE-1:0]));
`ifdef CSA_RESOLVE_COUT_EN
            chk($sformatf("cout%0d", i), 64'(cout_w[i]),
                64'(mon_e[SIZE]));
`endif
            if (i == 0 && trk) begin
              if (t_cnt == 0) t_first = cyc;
              t_last = cyc;
              t_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [SIZE-1:0] s,
                       input logic [SIZE-1:0] c);
    in_valid = 1'b1;
    in_s = s;
    in_c = c;
    step();
    in_valid = 1'b0;
    in_s = 'x;
    in_c = 'x;
  endtask

  task automatic measure(input string tag);
    int lat [NI];
    bit all;
    for (int i = 0; i < NI; i++) lat[i] = 0;
    for (int t = 1; t <= SIZE + 6; t++) begin
      all = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (lat[i] == 0 && vld_w[i]) lat[i] = t;
        if (lat[i] == 0) all = 1'b0;
      end
      if (all) break;
      step();
    end
    for (int i = 0; i < NI; i++)
      chk($sformatf("%s%0d", tag, i), 64'(lat[i]), 64'(lat_of(i)));
    step();
  endtask

  task automatic drain_check(input string tag);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (SIZE + 8) step();
    for (int i = 0; i < NI; i++)
      chk($sformatf("%s%0d", tag, i), 64'(q[i].size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_s = '0;
    in_c = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_vld%0d", i), 64'(vld_w[i]), 64'd0);
      chk($sformatf("rst_sum%0d", i), 64'(sum_w[i]), 64'd0);
      chk($sformatf("rst_rdy%0d", i), 64'(rdy_w[i]), 64'd1);
`ifdef CSA_RESOLVE_COUT_EN
      chk($sformatf("rst_cout%0d", i), 64'(cout_w[i]), 64'd0);
`endif
    end

    send1(34'h0_0000_0001, 34'h0_0000_0002);
    measure("lat_basic");
    send1(34'h3_FFFF_FFFF, 34'h0_0000_0001);
    measure("lat_ripple");
    drain_check("q_directed");

    t_cnt = 0;
    trk = 1'b1;
    for (int n = 0; n < 100; n++) begin
      in_valid = 1'b1;
      in_s = rnd();
      in_c = rnd();
      step();
    end
    drain_check("q_stream");
    trk = 1'b0;
    chk("stream_cnt", 64'(t_cnt), 64'd100);
    chk("stream_span", 64'(t_last - t_first + 1), 64'd100);

    for (int n = 0; n < 28; n++) begin
      in_valid = 1'b1;
      in_s = rnd();
      in_c = rnd();
      out_ready = !(n >= 8 && n < 18);
      if (!out_ready) begin
        #1;
        if (n == 8) begin
          held = sum_w[0];
        end else begin
          chk("bp_rdy", 64'(rdy_w[0]), 64'd0);
          chk("bp_vld", 64'(vld_w[0]), 64'd1);
          chk("bp_hold", 64'(sum_w[0]), 64'(held));
        end
      end
      step();
    end
    drain_check("q_bp");

    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      in_s = rnd();
      in_c = rnd();
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("pre_rst_vld", 64'(vld_w[0]), 64'd1);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mid_rst_vld%0d", i), 64'(vld_w[i]), 64'd0);
      q[i].delete();
    end
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    #1;
    send1(34'd5, 34'd7);
    measure("lat_rst");
    drain_check("q_rst");

    for (int n = 0; n < 300; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_s = rnd();
      in_c = rnd();
      step();
    end
    drain_check("q_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
